// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_pkg: arbiter state encoding, memory-map constants and requester id width
package mem_bus_pkg;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE = 2'b00;
  localparam arb_state_t ARB_OWN0 = 2'b01;
  localparam arb_state_t ARB_OWN1 = 2'b10;
  localparam logic [31:0] RAM_BASE = 32'h1001_0000;
  localparam logic [31:0] UART_BASE = 32'h1001_0020;
  localparam logic [31:0] STACK_TOP = 32'h7fff_effc;
  localparam int ID_W = 1;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: both requester ports plus the shared memory-map port
interface mem_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wd, m0_rd;
  logic                  m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wd, m1_rd;
  logic                  bus_we, bus_re;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wd, bus_rd;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd, m1_req, m1_we, m1_addr, m1_wd, bus_rd,
    output m0_gnt, m0_rvalid, m0_rd, m1_gnt, m1_rvalid, m1_rd, bus_we, bus_re, bus_addr, bus_wd
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wd, m1_req, m1_we, m1_addr, m1_wd, bus_rd,
    input  m0_gnt, m0_rvalid, m0_rd, m1_gnt, m1_rvalid, m1_rd, bus_we, bus_re, bus_addr, bus_wd
  );
endinterface

// File: rtl/mem_bus_arbiter_arb_rr_pick.sv
// arb_rr_pick: combinational next-owner choice for the round-robin arbiter
module arb_rr_pick
  import mem_bus_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_owner,
  input  arb_state_t cur_owner,
  input  logic       cap_hit,
  output arb_state_t next_state
);
  arb_state_t idle_pick, own0_pick, own1_pick;
  always_comb begin
    idle_pick  = (req0 & req1) ? (last_owner ? ARB_OWN0 : ARB_OWN1) :
                 req0 ? ARB_OWN0 : req1 ? ARB_OWN1 : ARB_IDLE;
    own0_pick  = req0 ? ((cap_hit & req1) ? ARB_OWN1 : ARB_OWN0) : (req1 ? ARB_OWN1 : ARB_IDLE);
    own1_pick  = req1 ? ((cap_hit & req0) ? ARB_OWN0 : ARB_OWN1) : (req0 ? ARB_OWN0 : ARB_IDLE);
    next_state = (cur_owner == ARB_OWN0) ? own0_pick :
                 (cur_owner == ARB_OWN1) ? own1_pick : idle_pick;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter with burst cap and 1-cycle read return
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  arb_state_t            state, nxt;
  logic                  last_owner, rd_pend;
  logic [ID_W-1:0]       rd_tag;
  logic [BW-1:0]         burst_cnt;
  logic                  own1, gnt0, gnt1, issue, cap_hit, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wd;
  logic                  rv0, rv1;
  always_comb begin
    own1     = state == ARB_OWN1;
    gnt0     = ~rst & (state == ARB_OWN0);
    gnt1     = ~rst & own1;
    issue    = (gnt0 & bus.m0_req) | (gnt1 & bus.m1_req);
    cap_hit  = burst_cnt == BW'(MAX_BURST - 1);
    sel_we   = own1 ? bus.m1_we : bus.m0_we;
    sel_addr = own1 ? bus.m1_addr : bus.m0_addr;
    sel_wd   = own1 ? bus.m1_wd : bus.m0_wd;
  end
  arb_rr_pick u_pick (
    .req0       (bus.m0_req),
    .req1       (bus.m1_req),
    .last_owner (last_owner),
    .cur_owner  (state),
    .cap_hit    (cap_hit),
    .next_state (nxt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      rd_pend    <= 1'b0;
      rd_tag     <= '0;
    end else begin
      state     <= nxt;
      if (state != ARB_IDLE && nxt != state) last_owner <= own1;
      burst_cnt <= (issue && nxt == state) ? (cap_hit ? burst_cnt : burst_cnt + 1'b1) : '0;
      rd_pend   <= issue & ~sel_we;
      if (issue) rd_tag <= ID_W'(own1);
    end
  end
  // Read data is a combinational pass of bus_rd, steered by the tag of the issuing owner
  always_comb begin
    rv0           = ~rst & rd_pend & (rd_tag == ID_W'(0));
    rv1           = ~rst & rd_pend & (rd_tag == ID_W'(1));
    bus.m0_gnt    = gnt0;
    bus.m1_gnt    = gnt1;
    bus.m0_rvalid = rv0;
    bus.m1_rvalid = rv1;
    bus.m0_rd     = rv0 ? bus.bus_rd : '0;
    bus.m1_rd     = rv1 ? bus.bus_rd : '0;
    bus.bus_we    = issue & sel_we;
    bus.bus_re    = issue & ~sel_we;
    bus.bus_addr  = issue ? sel_addr : '0;
    bus.bus_wd    = issue ? sel_wd : '0;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;
  localparam int MAXB = 4;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  mem_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  // model state: owner -1 = nobody, pending read queue holds at most one tag
  int m_own = -1, m_last = 1, m_burst = 0;
  int m_rdq[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_own = -1; m_last = 1; m_burst = 0; m_rdq.delete();
    end else begin
      bit mine, other, we;
      mine  = (m_own == 0) ? bus.m0_req : (m_own == 1) ? bus.m1_req : 1'b0;
      other = (m_own == 0) ? bus.m1_req : (m_own == 1) ? bus.m0_req : 1'b0;
      we    = (m_own == 1) ? bus.m1_we : bus.m0_we;
      m_rdq.delete();
      if (mine && !we) m_rdq.push_back(m_own);
      if (m_own < 0) begin
        if (bus.m0_req && bus.m1_req) m_own = 1 - m_last;
        else if (bus.m0_req) m_own = 0;
        else if (bus.m1_req) m_own = 1;
      end else if (mine) begin
        if (m_burst == MAXB - 1 && other) begin
          m_last = m_own; m_own = 1 - m_own; m_burst = 0;
        end else if (m_burst < MAXB - 1) m_burst++;
      end else begin
        m_last = m_own; m_burst = 0; m_own = other ? 1 - m_own : -1;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    bit g0, g1, iss, we, rv0, rv1;
    logic [31:0] a, d;
    g0  = !rst && m_own == 0;
    g1  = !rst && m_own == 1;
    iss = (g0 && bus.m0_req) || (g1 && bus.m1_req);
    we  = g1 ? bus.m1_we : bus.m0_we;
    a   = g1 ? bus.m1_addr : bus.m0_addr;
    d   = g1 ? bus.m1_wd : bus.m0_wd;
    rv0 = !rst && m_rdq.size() > 0 && m_rdq[0] == 0;
    rv1 = !rst && m_rdq.size() > 0 && m_rdq[0] == 1;
    chk("m0_gnt", 32'(bus.m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(bus.m1_gnt), 32'(g1));
    chk("bus_we", 32'(bus.bus_we), 32'(iss && we));
    chk("bus_re", 32'(bus.bus_re), 32'(iss && !we));
    chk("bus_addr", bus.bus_addr, iss ? a : 32'h0);
    chk("bus_wd", bus.bus_wd, iss ? d : 32'h0);
    chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(rv0));
    chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(rv1));
    chk("m0_rd", bus.m0_rd, rv0 ? bus.bus_rd : 32'h0);
    chk("m1_rd", bus.m1_rd, rv1 ? bus.bus_rd : 32'h0);
  end
  task automatic step();
    @(posedge clk);
    #1;
    bus.bus_rd = $urandom;
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    int nwe, nrv;
    bit i0, i1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wd = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wd = 0;
    bus.bus_rd = 0;
    step();
    chk_en = 1;
    do_reset();
    // single m0 read: grant after one cycle, data back the next
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = RAM_BASE + 32'h4;
    @(negedge clk);
    chk("t1 gnt latency", 32'(bus.m0_gnt), 32'h0);
    step();
    @(negedge clk);
    chk("t1 gnt", 32'(bus.m0_gnt), 32'h1);
    chk("t1 re", 32'(bus.bus_re), 32'h1);
    chk("t1 addr", bus.bus_addr, 32'h1001_0004);
    step();
    bus.m0_req = 0; bus.bus_rd = 32'h1234_5678;
    @(negedge clk);
    chk("t1 rvalid", 32'(bus.m0_rvalid), 32'h1);
    chk("t1 rd", bus.m0_rd, 32'h1234_5678);
    chk("t1 m1 rvalid", 32'(bus.m1_rvalid), 32'h0);
    step();
    // tie from reset: 4 m0 issues, gap-free handover, 4 m1 issues, back to m0
    do_reset();
    bus.m0_req = 1; bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = RAM_BASE + 32'h8;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t2 m0_gnt", 32'(bus.m0_gnt), 32'((c >= 1 && c <= 4) || c == 9));
      chk("t2 m1_gnt", 32'(bus.m1_gnt), 32'(c >= 5 && c <= 8));
      chk("t2 m0_rvalid", 32'(bus.m0_rvalid), 32'(c >= 2 && c <= 5));
      chk("t2 m1_rvalid", 32'(bus.m1_rvalid), 32'(c >= 6 && c <= 9));
      step();
    end
    bus.m0_req = 0; bus.m1_req = 0;
    // m1 write to the UART: exactly one write cycle, m0 sees no read data
    do_reset();
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = UART_BASE; bus.m1_wd = 32'hDEAD_BEEF;
    nwe = 0; nrv = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.bus_we && bus.bus_addr == 32'h1001_0020 && bus.bus_wd == 32'hDEAD_BEEF) nwe++;
      if (bus.m0_rvalid) nrv++;
      i1 = bus.m1_req & bus.m1_gnt;
      step();
      if (i1) bus.m1_req = 0;
    end
    chk("t3 write count", 32'(nwe), 32'h1);
    chk("t3 m0 rvalid count", 32'(nrv), 32'h0);
    // reset right after a read issues drops the read and returns to IDLE
    do_reset();
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = RAM_BASE;
    step();
    @(negedge clk);
    chk("t6 issue", 32'(bus.bus_re), 32'h1);
    step();
    rst = 1; bus.m0_req = 0;
    @(negedge clk);
    chk("t6 m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
    chk("t6 m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    chk("t6 gnt", 32'(bus.m0_gnt), 32'h0);
    step();
    rst = 0; bus.m0_req = 1; bus.m1_req = 1; bus.m1_we = 0;
    @(negedge clk);
    chk("t6 idle", 32'({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid}), 32'h0);
    step();
    @(negedge clk);
    chk("t6 m0 first", 32'({bus.m0_gnt, bus.m1_gnt}), 32'h2);
    // randomized traffic; requests are held until granted
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      i0 = bus.m0_req & bus.m0_gnt;
      i1 = bus.m1_req & bus.m1_gnt;
      step();
      rst = ($urandom_range(299) == 0);
      if (i0 || !bus.m0_req) begin
        bus.m0_req = ($urandom_range(3) != 0); bus.m0_we = $urandom;
        bus.m0_addr = RAM_BASE + 32'($urandom_range(63)) * 4; bus.m0_wd = $urandom;
      end
      if (i1 || !bus.m1_req) begin
        bus.m1_req = ($urandom_range(2) != 0); bus.m1_we = $urandom;
        bus.m1_addr = UART_BASE + 32'($urandom_range(7)) * 4; bus.m1_wd = $urandom;
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
